shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register: `DEPTH` stages, each `WIDTH` bits wide.
- Supports hold, shift right/left, rotate right/left and parallel load, selected per cycle by `mode`.
- Tracks how many stages hold freshly shifted-in data and flags when the register first fills.
- Used as the generic serialiser/deserialiser and delay-line primitive. With `WIDTH=1`, `DEPTH=4`, `mode=SHR` it behaves as the existing 4-stage serial-in/serial-out delay.

## Interface
Parameters
- `WIDTH`, default 1: bits per stage, ≥1.
- `DEPTH`, default 4: number of stages, ≥2.
- `CW`, derived: `$clog2(DEPTH+1)`, width of `valid_cnt`.

Ports
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `mode`  in  3  operation select; encodings under Operation.
- `sin_r`  in  WIDTH  serial input for SHR; enters stage 0.
- `sin_l`  in  WIDTH  serial input for SHL; enters stage DEPTH-1.
- `pdata`  in  WIDTH*DEPTH  parallel load data; stage k = `pdata[k*WIDTH +: WIDTH]`.
- `sout_r`  out  WIDTH  stage DEPTH-1 (right-shift serial output).
- `sout_l`  out  WIDTH  stage 0 (left-shift serial output).
- `pout`  out  WIDTH*DEPTH  all stages, same packing as `pdata`.
- `valid_cnt`  out  CW  number of stages filled since last reset/load, range 0..DEPTH.
- `full`  out  1  `valid_cnt == DEPTH`.
- `fill_pulse`  out  1  one-cycle flag, first fill reached by shifting.

## Operation
Mode encodings:
- 0 HOLD: no change.
- 1 SHR: s[0]←`sin_r`, s[k]←s[k-1].
- 2 SHL: s[DEPTH-1]←`sin_l`, s[k]←s[k+1].
- 3 ROTR: s[0]←s[DEPTH-1], s[k]←s[k-1].
- 4 ROTL: s[DEPTH-1]←s[0], s[k]←s[k+1].
- 5 LOAD: s[k]←pdata stage k.
- 6, 7: reserved; behave exactly as HOLD.

Counter rules:
- SHR/SHL: `valid_cnt` ← min(`valid_cnt`+1, DEPTH); saturates and never wraps.
- LOAD: `valid_cnt` ← DEPTH.
- HOLD, ROTR, ROTL and reserved modes: unchanged.

`fill_pulse`:
- Asserted only when a SHR/SHL edge moves `valid_cnt` from DEPTH-1 to DEPTH.
- High for exactly the one cycle in which `full` first reads 1.
- Not asserted by LOAD, and not re-asserted while saturated.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset: while `resetn`=0 at a rising edge, every stage, `valid_cnt`, `full` and `fill_pulse` become 0. Reset dominates any `mode`.
- Reset mid-operation discards contents and the fill count. The first edge with `resetn`=1 executes `mode` normally.
- Latency:
  - `sin_r` appears on `sout_r` after exactly DEPTH consecutive SHR edges.
  - `sin_l` appears on `sout_l` after exactly DEPTH consecutive SHL edges.
  - LOAD data is visible on `pout` the cycle after the edge.
- Mode may change on any cycle; there is no handshake and no illegal sequence.
- Mixing SHR and SHL keeps incrementing the counter. The count is a fill measure, not a direction-aware occupancy.

## Structure
- Shared package `shift_pkg`:
  - typedef `shift_mode_e` (3-bit enum: HOLD, SHR, SHL, ROTR, ROTL, LOAD).
  - constant `SHIFT_MODE_W=3`.
- Sub-module `shift_fill_ctr`:
  - Contains the saturating `valid_cnt`, `full` and `fill_pulse` logic.
  - Parameter `DEPTH`; inputs `clk`, `resetn`, `shift_en`, `load_en`.
- The stage array and mode decode stay in the top module.

## Test plan
1. `WIDTH`=1, `DEPTH`=4, SHR with `sin_r` = 1,0,1,1 over 4 edges.
   - `valid_cnt` = 1,2,3,4.
   - `fill_pulse` high only after the 4th edge.
   - `pout`=4'b1011; `sout_r`=1.
2. LOAD `pdata`=4'hA, then ROTR.
   - After LOAD: `pout`=4'hA, `valid_cnt`=4, `fill_pulse`=0.
   - 1 ROTR: `pout`=4'h5.
   - 4 ROTR total: `pout`=4'hA.
3. `WIDTH`=8, `DEPTH`=3, SHL with `sin_l` = 0x11,0x22,0x33.
   - After the 3rd edge: `pout`={0x33,0x22,0x11}, `sout_l`=0x11, `full`=1.
4. Two SHR edges, then `resetn`=0 for one edge with `mode`=LOAD, `pdata`=all ones.
   - `pout`=0, `valid_cnt`=0, `full`=0, `fill_pulse`=0.
5. From test 1's end state, 5 cycles each of HOLD, mode 6 and mode 7.
   - `pout`=4'b1011 and `valid_cnt`=4 throughout.
6. After full, 6 further SHR edges.
   - `valid_cnt` stays 4 and `fill_pulse` stays 0.
   - Data keeps shifting: `sout_r` follows `sin_r` delayed by 4 edges.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register family.
package shift_pkg;

  localparam int SHIFT_MODE_W = 3;

  // Operation select. Codes 6 and 7 are reserved and treated as HOLD.
  typedef enum logic [SHIFT_MODE_W-1:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    ROTR = 3'd3,
    ROTL = 3'd4,
    LOAD = 3'd5
  } shift_mode_e;

endpackage

// File: rtl/shift_fill_ctr.sv
// Saturating fill counter: counts shifted-in stages, flags full and the
// single cycle in which the register first fills by shifting.
module shift_fill_ctr #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          shift_en,
  input  logic          load_en,
  output logic [CW-1:0] valid_cnt,
  output logic          full,
  output logic          fill_pulse
);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          fill_q, fill_d;

  // Next count: LOAD fills outright, shifts increment and saturate at DEPTH.
  always_comb begin
    cnt_d  = cnt_q;
    fill_d = 1'b0;
    if (load_en) begin
      cnt_d = DEPTH_C;
    end else if (shift_en) begin
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + 1'b1;
      end
      fill_d = (cnt_q == DEPTH_M1_C);
    end
    full_d = (cnt_d == DEPTH_C);
  end

  // Registered counter and flags; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      fill_q <= fill_d;
    end
  end

  assign valid_cnt  = cnt_q;
  assign full       = full_q;
  assign fill_pulse = fill_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift,
// rotate and parallel load, plus a fill counter for serdes/delay-line use.
module shift_reg_univ #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [WIDTH*DEPTH-1:0] pdata,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [CW-1:0]          valid_cnt,
  output logic                   full,
  output logic                   fill_pulse
);

  import shift_pkg::*;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             shift_en;
  logic             load_en;

  // Mode decode; reserved codes fall through to hold.
  always_comb begin
    stage_d  = stage_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (shift_mode_e'(mode))
      SHR: begin
        shift_en   = 1'b1;
        stage_d[0] = sin_r;
        for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end
      SHL: begin
        shift_en         = 1'b1;
        stage_d[DEPTH-1] = sin_l;
        for (int k = 0; k < DEPTH - 1; k++) stage_d[k] = stage_q[k+1];
      end
      ROTR: begin
        stage_d[0] = stage_q[DEPTH-1];
        for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end
      ROTL: begin
        stage_d[DEPTH-1] = stage_q[0];
        for (int k = 0; k < DEPTH - 1; k++) stage_d[k] = stage_q[k+1];
      end
      LOAD: begin
        load_en = 1'b1;
        for (int k = 0; k < DEPTH; k++) stage_d[k] = pdata[k*WIDTH +: WIDTH];
      end
      default: begin
        stage_d = stage_q;
      end
    endcase
  end

  // Stage array register; reset clears every stage regardless of mode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Pack stages onto the parallel output, stage k in slice k.
  always_comb begin
    pout = '0;
    for (int k = 0; k < DEPTH; k++) pout[k*WIDTH +: WIDTH] = stage_q[k];
  end

  assign sout_r = stage_q[DEPTH-1];
  assign sout_l = stage_q[0];

  shift_fill_ctr #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fill_ctr (
    .clk        (clk),
    .resetn     (resetn),
    .shift_en   (shift_en),
    .load_en    (load_en),
    .valid_cnt  (valid_cnt),
    .full       (full),
    .fill_pulse (fill_pulse)
  );

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a 1x4 instance driven from a vector
// table and an 8x3 instance driven by a short hand-written sequence.
module tb_shift_reg_univ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 1-bit x 4 instance ----------------
  logic        a_resetn;
  logic [2:0]  a_mode;
  logic        a_sin_r, a_sin_l;
  logic [3:0]  a_pdata;
  logic        a_sout_r, a_sout_l;
  logic [3:0]  a_pout;
  logic [2:0]  a_cnt;
  logic        a_full, a_fill;

  shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut_a (
    .clk        (clk),
    .resetn     (a_resetn),
    .mode       (a_mode),
    .sin_r      (a_sin_r),
    .sin_l      (a_sin_l),
    .pdata      (a_pdata),
    .sout_r     (a_sout_r),
    .sout_l     (a_sout_l),
    .pout       (a_pout),
    .valid_cnt  (a_cnt),
    .full       (a_full),
    .fill_pulse (a_fill)
  );

  // ---------------- 8-bit x 3 instance ----------------
  logic        b_resetn;
  logic [2:0]  b_mode;
  logic [7:0]  b_sin_r, b_sin_l;
  logic [23:0] b_pdata;
  logic [7:0]  b_sout_r, b_sout_l;
  logic [23:0] b_pout;
  logic [1:0]  b_cnt;
  logic        b_full, b_fill;

  shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk        (clk),
    .resetn     (b_resetn),
    .mode       (b_mode),
    .sin_r      (b_sin_r),
    .sin_l      (b_sin_l),
    .pdata      (b_pdata),
    .sout_r     (b_sout_r),
    .sout_l     (b_sout_l),
    .pout       (b_pout),
    .valid_cnt  (b_cnt),
    .full       (b_full),
    .fill_pulse (b_fill)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rstn;
    logic [2:0] mode;
    logic       sr;
    logic       sl;
    logic [3:0] pd;
    logic [3:0] e_pout;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_fill;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rstn, input logic [2:0] mode,
                              input logic sr, input logic sl, input logic [3:0] pd,
                              input logic [3:0] e_pout, input logic [2:0] e_cnt,
                              input logic e_full, input logic e_fill);
    vec_t v;
    v.rstn = rstn; v.mode = mode; v.sr = sr; v.sl = sl; v.pd = pd;
    v.e_pout = e_pout; v.e_cnt = e_cnt; v.e_full = e_full; v.e_fill = e_fill;
    vecs.push_back(v);
  endfunction

  localparam logic [2:0] M_HOLD = 3'd0, M_SHR = 3'd1, M_SHL = 3'd2,
                         M_ROTR = 3'd3, M_ROTL = 3'd4, M_LOAD = 3'd5,
                         M_R6 = 3'd6, M_R7 = 3'd7;

  function automatic void fill_table();
    // reset dominates LOAD
    add(0, M_LOAD, 0, 0, 4'hF, 4'b0000, 0, 0, 0);
    // serial fill 1,0,1,1
    add(1, M_SHR, 1, 0, 4'h0, 4'b0001, 1, 0, 0);
    add(1, M_SHR, 0, 0, 4'h0, 4'b0010, 2, 0, 0);
    add(1, M_SHR, 1, 0, 4'h0, 4'b0101, 3, 0, 0);
    add(1, M_SHR, 1, 0, 4'h0, 4'b1011, 4, 1, 1);
    // HOLD and reserved codes freeze everything; inputs toggled to prove it
    for (int i = 0; i < 5; i++) add(1, M_HOLD, 1, 1, 4'h6, 4'b1011, 4, 1, 0);
    for (int i = 0; i < 5; i++) add(1, M_R6,   0, 1, 4'h3, 4'b1011, 4, 1, 0);
    for (int i = 0; i < 5; i++) add(1, M_R7,   1, 0, 4'hC, 4'b1011, 4, 1, 0);
    // saturated shifting: count stays 4, no new pulse, data keeps moving
    add(1, M_SHR, 0, 0, 4'h0, 4'b0110, 4, 1, 0);
    add(1, M_SHR, 0, 0, 4'h0, 4'b1100, 4, 1, 0);
    add(1, M_SHR, 1, 0, 4'h0, 4'b1001, 4, 1, 0);
    add(1, M_SHR, 1, 0, 4'h0, 4'b0011, 4, 1, 0);
    add(1, M_SHR, 0, 0, 4'h0, 4'b0110, 4, 1, 0);
    add(1, M_SHR, 1, 0, 4'h0, 4'b1101, 4, 1, 0);
    // SHL, ROTL, ROTR on a saturated register
    add(1, M_SHL,  0, 1, 4'h0, 4'b1110, 4, 1, 0);
    add(1, M_ROTL, 0, 0, 4'h0, 4'b0111, 4, 1, 0);
    add(1, M_ROTR, 0, 0, 4'h0, 4'b1110, 4, 1, 0);
    // LOAD A then four rotates right
    add(1, M_LOAD, 0, 0, 4'hA, 4'hA, 4, 1, 0);
    add(1, M_ROTR, 0, 0, 4'h0, 4'h5, 4, 1, 0);
    add(1, M_ROTR, 0, 0, 4'h0, 4'hA, 4, 1, 0);
    add(1, M_ROTR, 0, 0, 4'h0, 4'h5, 4, 1, 0);
    add(1, M_ROTR, 0, 0, 4'h0, 4'hA, 4, 1, 0);
    // reset mid-operation with LOAD of all ones pending
    add(0, M_LOAD, 1, 1, 4'hF, 4'b0000, 0, 0, 0);
    add(1, M_SHR,  1, 0, 4'h0, 4'b0001, 1, 0, 0);
    add(1, M_SHR,  1, 0, 4'h0, 4'b0011, 2, 0, 0);
    add(0, M_LOAD, 1, 1, 4'hF, 4'b0000, 0, 0, 0);
    // LOAD from empty: full without a pulse; further shift keeps it quiet
    add(1, M_LOAD, 0, 0, 4'h0, 4'b0000, 4, 1, 0);
    add(1, M_SHL,  0, 0, 4'h0, 4'b0000, 4, 1, 0);
    // mixed SHL/SHR fill reaches DEPTH and pulses
    add(0, M_HOLD, 0, 0, 4'h0, 4'b0000, 0, 0, 0);
    add(1, M_SHL,  0, 1, 4'h0, 4'b1000, 1, 0, 0);
    add(1, M_SHR,  1, 0, 4'h0, 4'b0001, 2, 0, 0);
    add(1, M_SHL,  0, 0, 4'h0, 4'b0000, 3, 0, 0);
    add(1, M_SHL,  0, 1, 4'h0, 4'b1000, 4, 1, 1);
    // LOAD at count DEPTH-1 must not pulse
    add(0, M_HOLD, 0, 0, 4'h0, 4'b0000, 0, 0, 0);
    add(1, M_SHR,  0, 0, 4'h0, 4'b0000, 1, 0, 0);
    add(1, M_SHR,  0, 0, 4'h0, 4'b0000, 2, 0, 0);
    add(1, M_SHR,  0, 0, 4'h0, 4'b0000, 3, 0, 0);
    add(1, M_LOAD, 0, 0, 4'h5, 4'b0101, 4, 1, 0);
    add(1, M_SHR,  0, 0, 4'h0, 4'b1010, 4, 1, 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_a(input vec_t v);
    a_resetn = v.rstn; a_mode = v.mode; a_sin_r = v.sr; a_sin_l = v.sl; a_pdata = v.pd;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rstn, input logic [2:0] mode,
                        input logic [7:0] sr, input logic [7:0] sl);
    b_resetn = rstn; b_mode = mode; b_sin_r = sr; b_sin_l = sl; b_pdata = 24'hFFFFFF;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] ep;
    a_resetn = 1'b0; a_mode = M_HOLD; a_sin_r = 1'b0; a_sin_l = 1'b0; a_pdata = '0;
    b_resetn = 1'b0; b_mode = M_HOLD; b_sin_r = '0;  b_sin_l = '0;  b_pdata = '0;
    @(posedge clk);
    #1;

    // Table-driven run on the 1x4 instance.
    fill_table();
    foreach (vecs[i]) begin
      step_a(vecs[i]);
      ep = vecs[i].e_pout;
      check("a_pout",   i, 32'(a_pout),   32'(ep));
      check("a_cnt",    i, 32'(a_cnt),    32'(vecs[i].e_cnt));
      check("a_full",   i, 32'(a_full),   32'(vecs[i].e_full));
      check("a_fill",   i, 32'(a_fill),   32'(vecs[i].e_fill));
      check("a_sout_r", i, 32'(a_sout_r), 32'(ep[3]));
      check("a_sout_l", i, 32'(a_sout_l), 32'(ep[0]));
    end

    // 8x3 instance: reset with LOAD pending, then SHL 0x11,0x22,0x33.
    step_b(1'b0, M_LOAD, 8'h00, 8'h00);
    check("b_rst_pout", 0, 32'(b_pout), 32'h0);
    check("b_rst_cnt",  0, 32'(b_cnt),  32'h0);
    step_b(1'b1, M_SHL, 8'h00, 8'h11);
    check("b_pout", 1, 32'(b_pout), 32'h110000);
    check("b_cnt",  1, 32'(b_cnt),  32'd1);
    check("b_full", 1, 32'(b_full), 32'd0);
    step_b(1'b1, M_SHL, 8'h00, 8'h22);
    check("b_pout", 2, 32'(b_pout), 32'h221100);
    check("b_fill", 2, 32'(b_fill), 32'd0);
    step_b(1'b1, M_SHL, 8'h00, 8'h33);
    check("b_pout",   3, 32'(b_pout),   32'h332211);
    check("b_sout_l", 3, 32'(b_sout_l), 32'h11);
    check("b_sout_r", 3, 32'(b_sout_r), 32'h33);
    check("b_cnt",    3, 32'(b_cnt),    32'd3);
    check("b_full",   3, 32'(b_full),   32'd1);
    check("b_fill",   3, 32'(b_fill),   32'd1);
    // one SHR on the wide instance: saturated, data moves toward stage 2
    step_b(1'b1, M_SHR, 8'h44, 8'h00);
    check("b_pout",   4, 32'(b_pout),   32'h221144);
    check("b_sout_r", 4, 32'(b_sout_r), 32'h22);
    check("b_cnt",    4, 32'(b_cnt),    32'd3);
    check("b_fill",   4, 32'(b_fill),   32'd0);
    // ROTL on the wide instance: stage 0 wraps to stage 2
    step_b(1'b1, M_ROTL, 8'h00, 8'h00);
    check("b_pout",   5, 32'(b_pout),   32'h442211);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
